async_fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's asynchronous FIFO. It runs entirely in the read clock domain and owns the read pointer. It synchronizes the Gray-coded write pointer arriving from the write domain, derives empty and fill level, and fetches words from the shared dual-port memory. Words are presented on a valid/ready output port. It is the reader counterpart of the FIFO write controller and exports its Gray read pointer back for the write side's full detection.

---
 rtl/async_fifo_rd_ctrl.sv | 111 +++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Async FIFO read-side controller: syncs the Gray write pointer, tracks
// empty/level, fetches from sync RAM and serves words on valid/ready.
module async_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] wsync1;
  logic [PW-1:0] wsync2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_nxt;
  logic          rd_inc;

  function automatic logic [PW-1:0] gray2bin(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wbin        = gray2bin(wsync2);
  assign rd_bin_nxt  = rd_bin + PW'(1);
  assign empty       = (rd_ptr_gray == wsync2);
  assign level       = wbin - rd_bin;
  assign mem_rd_addr = rd_bin[ADDR_WIDTH-1:0];
  assign mem_rd_en   = rd_inc;

  // reads are only issued when !empty, so underflow cannot occur
  always_comb begin
    state_nxt  = state;
    rd_inc     = 1'b0;
    dout_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          rd_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = VALID;
      end
      VALID: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (!empty) begin
            rd_inc    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wsync1      <= '0;
      wsync2      <= '0;
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      dout        <= '0;
      state       <= IDLE;
    end else begin
      wsync1 <= wr_ptr_gray;
      wsync2 <= wsync1;
      state  <= state_nxt;
      // gray is registered so the write domain sees a single-bit change
      if (rd_inc) begin
        rd_bin      <= rd_bin_nxt;
        rd_ptr_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      end
      if (state == FETCH) begin
        dout <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: models write side and sync RAM,
// scoreboards delivered words and read addresses.
module tb_async_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] wr_ptr_gray = '0;
  logic [PW-1:0] rd_ptr_gray;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          empty;
  logic [PW-1:0] level;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] q [$];
  logic [PW-1:0] wptr = '0;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int rd_cnt = 0;

  async_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .empty(empty),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    mem[wptr[AW-1:0]] = v;
    q.push_back(v);
    wptr = wptr + PW'(1);
    wr_ptr_gray = wptr ^ (wptr >> 1);
  endtask

  task automatic reset_all();
    rst = 1'b0;
    dout_ready = 1'b0;
    wptr = '0;
    wr_ptr_gray = '0;
    q.delete();
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // scoreboard: every transfer pops the expected word
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        logic [DW-1:0] e;
        e = q.pop_front();
        checks--;
        check("dout_word", {24'h0, dout}, {24'h0, e});
      end
      delivered++;
    end
  end

  // read-issue monitor: address and gray pointer follow the read count
  always @(negedge clk) begin
    if (!rst) begin
      rd_cnt = 0;
    end else if (mem_rd_en) begin
      logic [PW-1:0] k;
      k = rd_cnt[PW-1:0];
      check("rd_addr", {28'h0, mem_rd_addr}, {28'h0, k[AW-1:0]});
      check("rd_gray_pre", {27'h0, rd_ptr_gray}, {27'h0, k ^ (k >> 1)});
      rd_cnt++;
    end
  end

  initial begin
    int n;
    int d0;
    int written;
    logic [PW-1:0] g0;

    // reset with write pointer already at 2
    rst = 1'b0;
    mem[0] = 8'h10;
    mem[1] = 8'h11;
    push_word(8'h10);
    push_word(8'h11);
    repeat (3) tick();
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_valid", {31'h0, dout_valid}, 32'h0);
    check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_empty", {31'h0, empty}, 32'h1);
    check("rst_level", {27'h0, level}, 32'h0);
    check("rst_gray", {27'h0, rd_ptr_gray}, 32'h0);
    rst = 1'b1;
    tick();
    check("sync1_empty", {31'h0, empty}, 32'h1);
    tick();
    check("sync2_empty", {31'h0, empty}, 32'h0);
    check("sync2_level", {27'h0, level}, 32'h2);
    dout_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || dout_valid) && n < 30) begin
      tick();
      n++;
    end
    check("rst_drain_timeout", n < 30, 1);

    // single word
    reset_all();
    dout_ready = 1'b1;
    tick();
    push_word(8'hA5);
    tick();
    check("sw_e1_rd_en", {31'h0, mem_rd_en}, 32'h0);
    tick();
    check("sw_e2_rd_en", {31'h0, mem_rd_en}, 32'h1);
    check("sw_e2_addr", {28'h0, mem_rd_addr}, 32'h0);
    check("sw_e2_level", {27'h0, level}, 32'h1);
    tick();
    check("sw_e3_valid", {31'h0, dout_valid}, 32'h0);
    check("sw_e3_rd_en", {31'h0, mem_rd_en}, 32'h0);
    tick();
    check("sw_e4_valid", {31'h0, dout_valid}, 32'h1);
    check("sw_e4_dout", {24'h0, dout}, 32'hA5);
    tick();
    check("sw_e5_valid", {31'h0, dout_valid}, 32'h0);
    check("sw_e5_gray", {27'h0, rd_ptr_gray}, 32'h1);
    check("sw_e5_empty", {31'h0, empty}, 32'h1);

    // burst of three, alternate-cycle valid
    reset_all();
    dout_ready = 1'b1;
    tick();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    n = 0;
    while (!dout_valid && n < 10) begin
      tick();
      n++;
    end
    check("burst_wait", n < 10, 1);
    for (int i = 0; i < 5; i++) begin
      check("burst_alt", {31'h0, dout_valid}, (i % 2 == 0) ? 32'h1 : 32'h0);
      tick();
    end
    tick();
    check("burst_valid_end", {31'h0, dout_valid}, 32'h0);
    check("burst_empty", {31'h0, empty}, 32'h1);
    check("burst_level", {27'h0, level}, 32'h0);
    check("burst_gray", {27'h0, rd_ptr_gray}, 32'h2);

    // backpressure while holding 22
    reset_all();
    dout_ready = 1'b1;
    tick();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    n = 0;
    while (!(dout_valid && dout == 8'h22) && n < 20) begin
      tick();
      n++;
    end
    check("bp_wait", n < 20, 1);
    dout_ready = 1'b0;
    #1;
    g0 = rd_ptr_gray;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_dout", {24'h0, dout}, 32'h22);
      check("bp_valid", {31'h0, dout_valid}, 32'h1);
      check("bp_rd_en", {31'h0, mem_rd_en}, 32'h0);
      check("bp_gray", {27'h0, rd_ptr_gray}, {27'h0, g0});
    end
    dout_ready = 1'b1;
    #1;
    check("bp_release_rd_en", {31'h0, mem_rd_en}, 32'h1);
    n = 0;
    while ((q.size() != 0 || dout_valid) && n < 20) begin
      tick();
      n++;
    end
    check("bp_drain", n < 20, 1);

    // wrap-around: 40 words through depth 16
    reset_all();
    dout_ready = 1'b1;
    d0 = delivered;
    written = 0;
    n = 0;
    while ((written < 40 || delivered - d0 < 40) && n < 500) begin
      if (written < 40 && (written - (delivered - d0)) < 15) begin
        push_word(written[DW-1:0]);
        written++;
      end
      tick();
      n++;
    end
    check("wrap_timeout", n < 500, 1);
    repeat (3) tick();
    check("wrap_count", delivered - d0, 40);
    check("wrap_gray", {27'h0, rd_ptr_gray}, 32'h0C);
    check("wrap_empty", {31'h0, empty}, 32'h1);
    check("wrap_level", {27'h0, level}, 32'h0);

    // reset while holding a word
    reset_all();
    tick();
    push_word(8'h77);
    push_word(8'h88);
    n = 0;
    while (!dout_valid && n < 10) begin
      tick();
      n++;
    end
    check("mid_wait", n < 10, 1);
    check("mid_dout_pre", {24'h0, dout}, 32'h77);
    rst = 1'b0;
    wptr = '0;
    wr_ptr_gray = '0;
    q.delete();
    tick();
    check("mid_valid", {31'h0, dout_valid}, 32'h0);
    check("mid_dout", {24'h0, dout}, 32'h0);
    check("mid_gray", {27'h0, rd_ptr_gray}, 32'h0);
    check("mid_empty", {31'h0, empty}, 32'h1);
    rst = 1'b1;
    repeat (4) tick();
    check("mid_idle", {31'h0, dout_valid}, 32'h0);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
